// File: rtl/lcd_text_refresher.sv
// rtl/lcd_text_refresher.sv - 4x20 shadow text buffer that schedules hd44780 driver init and dirty-row refresh
// Host writes land in the buffer at any time; changed rows are pushed as one address instruction plus 20 data bytes.
module lcd_text_refresher #(
   parameter int unsigned STARTUP_CYCLES = 100_000_000,
   parameter int unsigned ACK_TIMEOUT    = 1_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [1:0] wr_row,
   input  logic [4:0] wr_col,
   input  logic [7:0] wr_data,
   output logic [1:0] lcd_cmd,
   output logic [8:0] lcd_vchr,
   input  logic       lcd_busy,
   output logic       ready,
   output logic       refreshing,
   output logic       error
);

   localparam logic [1:0] CMD_IDLE  = 2'd0;
   localparam logic [1:0] CMD_INIT  = 2'd1;
   localparam logic [1:0] CMD_WRITE = 2'd2;

   typedef enum logic [2:0] {
      WAIT_PWR, INIT_REQ, INIT_WAIT, IDLE, REQ, WAIT, NEXT
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [4:0]  col_q, col_d;
   logic [1:0]  row_q, row_d;
   logic [1:0]  last_q, last_d;
   logic [8:0]  vchr_q, vchr_d;
   logic [3:0]  dirty_q, dirty_d;
   logic        ready_q, ready_d;
   logic        refreshing_q, refreshing_d;
   logic        error_q, error_d;
   logic [7:0]  text_q [0:79];

   logic        wr_ok;
   logic [6:0]  wr_idx;
   logic [6:0]  rd_idx;
   logic [1:0]  pick;
   logic [1:0]  cand;

   function automatic logic [7:0] row_addr(input logic [1:0] r);
      case (r)
         2'd0:    row_addr = 8'h80;
         2'd1:    row_addr = 8'hC0;
         2'd2:    row_addr = 8'h94;
         default: row_addr = 8'hD4;
      endcase
   endfunction

   assign wr_ok  = wr_en && (wr_col < 5'd20);
   assign wr_idx = {5'd0, wr_row} * 7'd20 + {2'd0, wr_col};
   assign rd_idx = {5'd0, row_q} * 7'd20 + {2'd0, col_q};

   // Round-robin: nearest dirty row after the last one refreshed wins.
   always_comb begin
      pick = last_q + 2'd1;
      cand = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         cand = last_q + 2'(k);
         if (dirty_q[cand]) pick = cand;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      col_d        = col_q;
      row_d        = row_q;
      last_d       = last_q;
      vchr_d       = vchr_q;
      dirty_d      = dirty_q;
      ready_d      = ready_q;
      refreshing_d = refreshing_q;
      error_d      = error_q;
      lcd_cmd      = CMD_IDLE;
      case (state_q)
         WAIT_PWR: begin
            if (cnt_q == STARTUP_CYCLES - 1) begin
               state_d = INIT_REQ;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         INIT_REQ: begin
            lcd_cmd = CMD_INIT;
            cnt_d   = cnt_q + 32'd1;
            if (lcd_busy) begin
               state_d = INIT_WAIT;
               cnt_d   = '0;
            end else if (cnt_q == ACK_TIMEOUT - 1) begin
               error_d = 1'b1;
               ready_d = 1'b0;
               state_d = WAIT_PWR;
               cnt_d   = '0;
            end
         end
         INIT_WAIT: begin
            if (!lcd_busy) begin
               ready_d = 1'b1;
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (|dirty_q) begin
               vchr_d        = {1'b1, row_addr(pick)};
               row_d         = pick;
               last_d        = pick;
               col_d         = '0;
               dirty_d[pick] = 1'b0;
               refreshing_d  = 1'b1;
               cnt_d         = '0;
               state_d       = REQ;
            end
         end
         REQ: begin
            lcd_cmd = CMD_WRITE;
            cnt_d   = cnt_q + 32'd1;
            if (lcd_busy) begin
               state_d = WAIT;
               cnt_d   = '0;
            end else if (cnt_q == ACK_TIMEOUT - 1) begin
               // The interrupted row is marked dirty again so it is resent after re-init.
               error_d        = 1'b1;
               ready_d        = 1'b0;
               refreshing_d   = 1'b0;
               dirty_d[row_q] = 1'b1;
               state_d        = WAIT_PWR;
               cnt_d          = '0;
            end
         end
         WAIT: begin
            if (!lcd_busy) state_d = NEXT;
         end
         NEXT: begin
            if (col_q < 5'd20) begin
               vchr_d  = {1'b0, text_q[rd_idx]};
               col_d   = col_q + 5'd1;
               cnt_d   = '0;
               state_d = REQ;
            end else begin
               refreshing_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = WAIT_PWR;
      endcase
      // Applied last so a host write beats the clear of the row being issued.
      if (wr_ok) dirty_d[wr_row] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= WAIT_PWR;
         cnt_q        <= '0;
         col_q        <= '0;
         row_q        <= '0;
         last_q       <= 2'd3;
         vchr_q       <= '0;
         dirty_q      <= 4'b1111;
         ready_q      <= 1'b0;
         refreshing_q <= 1'b0;
         error_q      <= 1'b0;
         for (int i = 0; i < 80; i++) text_q[i] <= 8'h20;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         col_q        <= col_d;
         row_q        <= row_d;
         last_q       <= last_d;
         vchr_q       <= vchr_d;
         dirty_q      <= dirty_d;
         ready_q      <= ready_d;
         refreshing_q <= refreshing_d;
         error_q      <= error_d;
         if (wr_ok) text_q[wr_idx] <= wr_data;
      end
   end

   assign lcd_vchr   = vchr_q;
   assign ready      = ready_q;
   assign refreshing = refreshing_q;
   assign error      = error_q;

endmodule

// File: tb/tb_lcd_text_refresher.sv
// tb/tb_lcd_text_refresher.sv - scoreboard bench for lcd_text_refresher with a busy-pulse driver model
module tb_lcd_text_refresher;
   localparam int SC = 10;
   localparam int AT = 50;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [1:0] wr_row;
   logic [4:0] wr_col;
   logic [7:0] wr_data;
   logic [1:0] lcd_cmd;
   logic [8:0] lcd_vchr;
   logic       lcd_busy = 1'b0;
   logic       ready, refreshing, error;

   lcd_text_refresher #(.STARTUP_CYCLES(SC), .ACK_TIMEOUT(AT)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
      .wr_data(wr_data), .lcd_cmd(lcd_cmd), .lcd_vchr(lcd_vchr), .lcd_busy(lcd_busy),
      .ready(ready), .refreshing(refreshing), .error(error)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail = 0;
   int         n_seen = 0;
   logic       stall = 1'b0;
   int         bcnt = 0;
   logic       prev_busy = 1'b0;
   logic [10:0] exp_q[$];
   logic [7:0] mbuf [0:79];

   // Driver: accepts any request and holds busy for five cycles.
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         lcd_busy = 1'b0;
         bcnt = 0;
      end else if (lcd_busy) begin
         bcnt = bcnt - 1;
         if (bcnt == 0) lcd_busy = 1'b0;
      end else if (lcd_cmd != 2'd0 && !stall) begin
         lcd_busy = 1'b1;
         bcnt = 5;
      end
   end

   // Monitor: every rising busy marks one accepted transaction.
   always @(negedge clk) begin
      logic [10:0] e;
      if (rst_n && lcd_busy && !prev_busy) begin
         n_seen++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_txn: got cmd=%0d vchr=%03h, required no transaction", lcd_cmd, lcd_vchr);
         end else begin
            e = exp_q.pop_front();
            if (e[10:9] != lcd_cmd || (e[10:9] == 2'd2 && e[8:0] != lcd_vchr)) begin
               n_fail++;
               $display("FAIL txn_%0d: got cmd=%0d vchr=%03h, required cmd=%0d vchr=%03h",
                        n_seen, lcd_cmd, lcd_vchr, e[10:9], e[8:0]);
            end
         end
      end
      prev_busy = rst_n ? lcd_busy : 1'b0;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] addr_of(input int r);
      case (r)
         0: return 8'h80;
         1: return 8'hC0;
         2: return 8'h94;
         default: return 8'hD4;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 80; i++) mbuf[i] = 8'h20;
   endtask

   task automatic mwrite(input int r, input int c, input logic [7:0] d);
      if (c < 20) mbuf[r*20 + c] = d;
   endtask

   task automatic expect_init();
      exp_q.push_back({2'd1, 9'd0});
   endtask

   task automatic expect_row(input int r);
      exp_q.push_back({2'd2, 1'b1, addr_of(r)});
      for (int c = 0; c < 20; c++) exp_q.push_back({2'd2, 1'b0, mbuf[r*20 + c]});
   endtask

   task automatic dut_write(input int r, input int c, input logic [7:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_row = 2'(r); wr_col = 5'(c); wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_seen(input int target);
      int t = 0;
      while (n_seen < target && t < 4000) begin
         @(posedge clk);
         t++;
      end
      chk("wait_seen_bound", (n_seen >= target) ? 1 : 0, 1);
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 8000) begin
         @(posedge clk);
         t++;
      end
      chk({name, "_drained"}, exp_q.size(), 0);
      repeat (30) @(posedge clk);
      #1;
      chk({name, "_idle"}, int'(refreshing), 0);
   endtask

   initial begin
      int cyc, n, f, r0, k;
      logic [3:0] dmask;
      int br[4], bc[4];
      logic [7:0] bd[4];

      rst_n = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd", int'(lcd_cmd), 0);
      chk("rst_vchr", int'(lcd_vchr), 0);
      chk("rst_ready", int'(ready), 0);
      chk("rst_refreshing", int'(refreshing), 0);
      chk("rst_error", int'(error), 0);

      // Power-up: init after STARTUP_CYCLES, then rows 0..3 of blanks.
      expect_init();
      for (int r = 0; r < 4; r++) expect_row(r);
      rst_n = 1'b1;
      cyc = 0;
      for (int i = 1; i <= 40 && cyc == 0; i++) begin
         @(posedge clk);
         #1;
         if (lcd_cmd == 2'd1) cyc = i;
      end
      chk("init_cycle", cyc, SC);
      drain("powerup");
      chk("ready_after_init", int'(ready), 1);

      // Single write to row2 col5.
      mwrite(2, 5, 8'h41);
      expect_row(2);
      dut_write(2, 5, 8'h41);
      drain("single_write");

      // Write to an already-sent column while the same row is in flight.
      mwrite(1, 0, 8'h61);
      expect_row(1);
      n = n_seen;
      dut_write(1, 0, 8'h61);
      wait_seen(n + 12);
      mwrite(1, 3, 8'h5A);
      expect_row(1);
      dut_write(1, 3, 8'h5A);
      drain("write_during_refresh");

      // Out-of-range column is ignored entirely.
      dut_write(0, 25, 8'hEE);
      repeat (60) @(posedge clk);
      #1;
      chk("oor_no_refresh", int'(refreshing), 0);

      // Second write lands on the address-issue edge: row1 goes out twice.
      mwrite(1, 7, 8'h31);
      mwrite(1, 8, 8'h32);
      expect_row(1);
      expect_row(1);
      @(negedge clk);
      wr_en = 1'b1; wr_row = 2'd1; wr_col = 5'd7; wr_data = 8'h31;
      @(negedge clk);
      wr_col = 5'd8; wr_data = 8'h32;
      @(negedge clk);
      wr_en = 1'b0;
      drain("same_cycle_write");

      // Random write bursts from idle: the first valid write's row goes out at once,
      // later writes in the burst mark their rows for round-robin follow-up.
      for (int b = 0; b < 8; b++) begin
         k = $urandom_range(1, 4);
         f = -1;
         dmask = 4'b0;
         for (int i = 0; i < k; i++) begin
            br[i] = $urandom_range(0, 3);
            bc[i] = $urandom_range(0, 24);
            bd[i] = 8'($urandom_range(0, 255));
            mwrite(br[i], bc[i], bd[i]);
            if (bc[i] < 20) begin
               if (f < 0) f = i;
               else dmask[br[i]] = 1'b1;
            end
         end
         if (f >= 0) begin
            r0 = br[f];
            expect_row(r0);
            for (int j = 1; j <= 4; j++)
               if (dmask[(r0 + j) % 4]) expect_row((r0 + j) % 4);
         end
         for (int i = 0; i < k; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_row = 2'(br[i]); wr_col = 5'(bc[i]); wr_data = bd[i];
         end
         @(negedge clk);
         wr_en = 1'b0;
         drain("random_burst");
      end

      // Driver never acknowledges: timeout after ACK_TIMEOUT cycles, then re-init.
      stall = 1'b1;
      mwrite(3, 0, 8'h33);
      dut_write(3, 0, 8'h33);
      n = 0;
      for (int i = 0; i < 300 && !error; i++) begin
         @(posedge clk);
         #1;
         if (lcd_cmd == 2'd2) n++;
      end
      chk("timeout_cycles", n, AT);
      chk("timeout_error", int'(error), 1);
      chk("timeout_ready", int'(ready), 0);
      expect_init();
      expect_row(3);
      stall = 1'b0;
      drain("retry");
      chk("retry_ready", int'(ready), 1);
      chk("error_sticky", int'(error), 1);

      // Asynchronous reset in the middle of a data transaction.
      mwrite(0, 0, 8'h44);
      expect_row(0);
      n = n_seen;
      dut_write(0, 0, 8'h44);
      wait_seen(n + 4);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_cmd", int'(lcd_cmd), 0);
      chk("arst_vchr", int'(lcd_vchr), 0);
      chk("arst_ready", int'(ready), 0);
      chk("arst_refreshing", int'(refreshing), 0);
      chk("arst_error", int'(error), 0);
      exp_q.delete();
      model_reset();
      expect_init();
      for (int r = 0; r < 4; r++) expect_row(r);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      drain("reboot");
      chk("reboot_ready", int'(ready), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: got no end of test, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lcd_text_refresher.md
# lcd_text_refresher

Scheduler that owns the hd44780 character-LCD driver on behalf of the rest of the design. It keeps an 80-byte shadow text buffer (4 rows × 20 columns), accepts single-cycle character writes from any host logic, and sequences the driver's cmd/vchr/busy handshake to run power-up init, then push only the rows that changed. It replaces the hand-written demo sequencers in top-level test modules.

## Interface
- STARTUP_CYCLES, default 100_000_000: clk cycles to wait after reset before requesting init (1 s at 100 MHz).
- ACK_TIMEOUT, default 1_000_000: cycles to wait for driver busy to rise after a request before flagging an error.
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  host write strobe, one character per cycle.
- wr_row  in  2  target row 0..3.
- wr_col  in  5  target column 0..19; values 20..31 are ignored.
- wr_data  in  8  character code.
- lcd_cmd  out  2  request to driver: 0 IDLE, 1 INIT, 2 WRITE.
- lcd_vchr  out  9  driver operand: bit8=1 instruction byte, bit8=0 data byte in [7:0].
- lcd_busy  in  1  driver busy flag.
- ready  out  1  high once driver init has completed.
- refreshing  out  1  high while a row transfer is in progress.
- error  out  1  sticky; set on handshake timeout, cleared only by reset.

## Operation
- Buffer: 80 × 8 register array plus dirty[3:0]. Reset fills every byte with 0x20 and sets dirty=4'b1111.
- Host write: wr_en with wr_col<20 stores wr_data at [wr_row][wr_col] on that edge and sets dirty[wr_row]. Writes are accepted in every state, including during refresh and before ready.
- Dirty clear rule: dirty[r] is cleared on the cycle row r's address transfer is issued. A same-cycle host write to row r wins, leaving dirty[r] set. A write to the row being refreshed re-dirties it, so the row is sent again later; no update is lost.
- Row address instructions: row0 0x80, row1 0xC0, row2 0x94, row3 0xD4. These are sent as lcd_vchr = {1'b1, addr}.
- Row selection: round-robin, starting at the row after the last one refreshed (after reset the scan starts at row 0).
- States:
  - WAIT_PWR: count STARTUP_CYCLES, then go to INIT_REQ.
  - INIT_REQ: hold lcd_cmd=INIT until lcd_busy=1, then go to INIT_WAIT.
  - INIT_WAIT: lcd_cmd=IDLE; when lcd_busy=0, set ready and go to IDLE.
  - IDLE: if any dirty bit is set, pick a row, load lcd_vchr with its address, set col=0, and go to REQ.
  - REQ: hold lcd_cmd=WRITE until lcd_busy=1, then go to WAIT.
  - WAIT: lcd_cmd=IDLE; when lcd_busy=0, go to NEXT.
  - NEXT:
    - If the last transfer was the address, or col<20: load {1'b0, buf[row][col]}, increment col, go to REQ.
    - Otherwise (col reached 20 after the last data byte): go to IDLE.
- refreshing is high from address load until the return to IDLE.
- Timeout: in INIT_REQ or REQ, if lcd_busy has not risen within ACK_TIMEOUT cycles, set error, drive lcd_cmd=IDLE and return to WAIT_PWR with ready=0, so the block re-inits. Dirty bits are kept.
- Reset mid-transfer: all state and buffer are reinitialised immediately (asynchronous); the driver sees lcd_cmd=IDLE.

## Timing
- Reset values: lcd_cmd=0, lcd_vchr=0, ready=0, refreshing=0, error=0, state=WAIT_PWR.
- lcd_vchr is registered and stable from the first REQ cycle until lcd_busy falls.
- lcd_cmd drops to IDLE on the first clock edge after lcd_busy is sampled high, so the driver sees each request exactly once.
- From IDLE with a dirty row, lcd_cmd=WRITE is asserted on the 2nd edge.
- Between successive transfers, the gap after lcd_busy falls is 2 cycles (WAIT→NEXT→REQ).
- A full row is 21 driver transactions: 1 address + 20 data bytes.

## Test plan
- Power-up: use STARTUP_CYCLES=10 and a driver model with busy high for 5 cycles. Required: INIT is asserted at cycle 10, ready rises after busy falls, then all four rows refresh in order 0,1,2,3, for 84 transactions, each data byte 0x20.
- Single write: write 'A' (0x41) to row2, col5 while idle. Required: exactly 21 transactions: 0x194, then 20 data bytes with the 6th = 0x041; no other row is sent.
- Write during refresh: while row1 col10 is being sent, write 0x5A to row1 col3. Required: after the row finishes, row1 is re-sent and includes 0x05A at col3.
- Out-of-range and simultaneous writes: a write with col=25 leaves the buffer and dirty bits unchanged. A write landing on the same cycle as the address issue keeps the dirty bit set.
- Timeout: with ACK_TIMEOUT=50 and a driver that never raises busy, error sets at cycle 50 of REQ, ready drops, and init is retried.
- Async reset mid-row: assert rst_n low during a data transaction. Required: outputs go to reset values immediately, and the next boot refreshes all four rows.
